mc_control_unit: RTL



---
 rtl/mc_control_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//   Control FSM of the multicycle CPU. It decodes the 6-bit opcode held in the
//   instruction register and walks each instruction through IF/ID/EXE/MEM/WB,
//   driving the datapath control lines for every state. Each instruction
//   writes the PC exactly once, in its final cycle, with the matching
//   next-PC select.
//
// Optional feature:
//   MC_BNE_EN - when defined, opcode 110101 is bne and follows the beq path.
//               When undefined, 110101 is an unknown opcode (2-cycle NOP).
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous active-high reset, forces sIF
//   OP         in   6  opcode IR[31:26], valid from sID onward
//   zero       in   1  ALU zero flag, valid in sEXE_B
//   PCWre      out  1  PC write enable
//   PCSrc      out  2  00 pc+4, 01 branch target, 10 rs, 11 jump target
//   IRWre      out  1  instruction register load
//   ALUSrcB    out  1  0 = rt, 1 = extended immediate
//   ALUOp      out  3  000 add, 001 sub, 010 or, 011 and, 100 slt
//   ExtSel     out  1  1 = sign-extend, 0 = zero-extend
//   RegWre     out  1  register file write
//   RegDst     out  2  00 rt, 01 rd, 10 $31
//   WrRegData  out  1  0 = ALU/PC4 result, 1 = memory data
//   mRD, mWR   out  1  data memory read / write strobes
//   state      out  3  current state (sHALT reports 001)
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegData,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] state
);

    // Bit 3 is the internal halt flag; the visible code is the low 3 bits.
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_L   = 4'b0100,
        S_EXE_B  = 4'b0101,
        S_EXE_R  = 4'b0110,
        S_WB_R   = 4'b0111,
        S_HALT   = 4'b1001
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_is_rtype, w_is_imm, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic       w_is_j, w_is_jr, w_is_jal, w_is_halt, w_is_known;
    logic       w_ends_in_id, w_taken;
    logic [2:0] w_alu_op;
    logic       w_pc_wre, w_reg_wre, w_mem_wr;
    logic [1:0] w_pc_src;

    // ---------------- opcode decode ----------------
    assign w_is_rtype = (OP == OP_ADD) || (OP == OP_SUB) || (OP == OP_OR) ||
                        (OP == OP_AND) || (OP == OP_SLT);
    assign w_is_imm   = (OP == OP_ADDI) || (OP == OP_ORI);
    assign w_is_lw    = (OP == OP_LW);
    assign w_is_sw    = (OP == OP_SW);
    assign w_is_beq   = (OP == OP_BEQ);
`ifdef MC_BNE_EN
    assign w_is_bne   = (OP == OP_BNE);
`else
    assign w_is_bne   = 1'b0;
`endif
    assign w_is_j     = (OP == OP_J);
    assign w_is_jr    = (OP == OP_JR);
    assign w_is_jal   = (OP == OP_JAL);
    assign w_is_halt  = (OP == HALT_OP);
    assign w_is_known = w_is_rtype | w_is_imm | w_is_lw | w_is_sw | w_is_beq |
                        w_is_bne | w_is_j | w_is_jr | w_is_jal | w_is_halt;

    // Jumps and unknown opcodes (NOPs) retire in sID.
    assign w_ends_in_id = w_is_j | w_is_jr | w_is_jal | ~w_is_known;
    assign w_taken      = (w_is_beq & zero) | (w_is_bne & ~zero);

    // ALU function depends only on the opcode, so it stays stable through
    // every EXE/MEM/WB state of the instruction.
    always_comb begin
        unique case (OP)
            OP_SUB:        w_alu_op = 3'b001;
            OP_OR, OP_ORI: w_alu_op = 3'b010;
            OP_AND:        w_alu_op = 3'b011;
            OP_SLT:        w_alu_op = 3'b100;
            default:       w_alu_op = 3'b000;
        endcase
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; combinational blocks below use blocking.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IF;
        else       r_state <= w_next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = S_IF;
        unique case (r_state)
            S_IF:     w_next_state = S_ID;
            S_ID: begin
                if (w_is_halt)                w_next_state = S_HALT;
                else if (w_is_beq | w_is_bne) w_next_state = S_EXE_B;
                else if (w_is_lw | w_is_sw)   w_next_state = S_EXE_LS;
                else if (w_is_rtype | w_is_imm) w_next_state = S_EXE_R;
                else                          w_next_state = S_IF;
            end
            S_EXE_LS: w_next_state = S_MEM;
            S_MEM:    w_next_state = w_is_lw ? S_WB_L : S_IF;
            S_WB_L:   w_next_state = S_IF;
            S_EXE_B:  w_next_state = S_IF;
            S_EXE_R:  w_next_state = S_WB_R;
            S_WB_R:   w_next_state = S_IF;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IF;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        IRWre     = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        RegDst    = 2'b00;
        WrRegData = 1'b0;
        mRD       = 1'b0;
        w_pc_wre  = 1'b0;
        w_pc_src  = 2'b00;
        w_reg_wre = 1'b0;
        w_mem_wr  = 1'b0;
        unique case (r_state)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                w_pc_wre = w_ends_in_id;
                if (w_is_j | w_is_jal) w_pc_src = 2'b11;
                else if (w_is_jr)      w_pc_src = 2'b10;
                // jal writes pc+4 to $31 in the same cycle the PC updates.
                if (w_is_jal) begin
                    w_reg_wre = 1'b1;
                    RegDst    = 2'b10;
                end
            end
            S_EXE_R, S_WB_R: begin
                ALUSrcB = w_is_imm;
                ExtSel  = (OP == OP_ADDI);
                ALUOp   = w_alu_op;
                RegDst  = w_is_rtype ? 2'b01 : 2'b00;
                if (r_state == S_WB_R) begin
                    w_reg_wre = 1'b1;
                    w_pc_wre  = 1'b1;
                end
            end
            S_EXE_LS, S_MEM, S_WB_L: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (r_state == S_MEM) begin
                    mRD      = w_is_lw;
                    w_mem_wr = w_is_sw;
                    w_pc_wre = w_is_sw;
                end
                if (r_state == S_WB_L) begin
                    w_reg_wre = 1'b1;
                    WrRegData = 1'b1;
                    w_pc_wre  = 1'b1;
                end
            end
            S_EXE_B: begin
                ALUOp    = 3'b001;
                ExtSel   = 1'b1;
                w_pc_wre = 1'b1;
                w_pc_src = w_taken ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    // A reset cycle must never commit any architectural write.
    assign PCWre  = w_pc_wre  & ~reset;
    assign PCSrc  = reset ? 2'b00 : w_pc_src;
    assign RegWre = w_reg_wre & ~reset;
    assign mWR    = w_mem_wr  & ~reset;
    assign state  = r_state[2:0];

endmodule
